// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared drive-instruction types and sequencer states
package robot_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_REV   = 2'b11
  } dir_t;

  typedef struct packed {
    logic [1:0] torque;
    dir_t       dir;
  } instr_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - strobe, instruction and status bundle of the sequencer
interface instruction_sequencer_if #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic               save_pulse;
  logic               delete_pulse;
  logic               execute_pulse;
  logic [INSTR_W-1:0] instr_in;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               busy;
  logic [CW-1:0]      count;
  logic [IW-1:0]      step_idx;
  logic               full;
  logic               empty;
  logic               done_pulse;

  modport master (
    output save_pulse, delete_pulse, execute_pulse, instr_in,
    input  instr_out, instr_valid, busy, count, step_idx, full, empty, done_pulse
  );

  modport slave (
    input  save_pulse, delete_pulse, execute_pulse, instr_in,
    output instr_out, instr_valid, busy, count, step_idx, full, empty, done_pulse
  );

endinterface

// File: rtl/step_timer.sv
// rtl/step_timer.sv - up/down step counter with clear and one-cycle terminal-count tick
module step_timer #(
  parameter int CYCLES = 4,
  parameter bit DOWN   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] FIRST = DOWN ? W'(CYCLES - 1) : '0;
  localparam logic [W-1:0] LAST  = DOWN ? '0 : W'(CYCLES - 1);

  logic [W-1:0] value;

  assign tick = enable && (value == LAST);

  // Terminal count reloads so back-to-back steps need no explicit restart.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      value <= FIRST;
    end else if (tick) begin
      value <= FIRST;
    end else if (enable) begin
      value <= DOWN ? value - W'(1) : value + W'(1);
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - records drive instructions and replays them one step per timer period
module instruction_sequencer
  import robot_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int INSTR_W     = 4,
  parameter int STEP_CYCLES = CLK_HZ
) (
  input logic                    CLOCK_50,
  input logic                    reset_n,
  instruction_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state, state_next;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [CW-1:0]      count;
  logic [IW-1:0]      step_idx;
  logic [IW-1:0]      next_idx;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               done_pulse;
  logic               full, empty;
  logic               start, tick, last_step, finish, do_save;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign next_idx  = step_idx + IW'(1);
  assign last_step = (CW'(step_idx) == count - CW'(1));
  assign start     = (state == S_IDLE) && bus.execute_pulse && !empty;
  assign finish    = (state == S_RUN) && tick && last_step;
  // Execute outranks delete, which outranks save.
  assign do_save   = (state == S_IDLE) && bus.save_pulse && !bus.execute_pulse
                     && !bus.delete_pulse && !full;

  step_timer #(.CYCLES(STEP_CYCLES)) u_step_timer (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .clear   (start),
    .enable  (state == S_RUN),
    .tick    (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)  state_next = S_RUN;
      S_RUN:   if (finish) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The instruction store is never cleared; only count decides what is live.
  always_ff @(posedge CLOCK_50) begin
    if (do_save) mem[count[IW-1:0]] <= bus.instr_in;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      count       <= '0;
      step_idx    <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      done_pulse <= finish;
      if (state == S_IDLE) begin
        if (bus.execute_pulse) begin
          if (!empty) begin
            step_idx    <= '0;
            instr_out   <= mem[0];
            instr_valid <= 1'b1;
          end
        end else if (bus.delete_pulse) begin
          if (!empty) count <= count - CW'(1);
        end else if (do_save) begin
          count <= count + CW'(1);
        end
      end else if (tick) begin
        if (last_step) begin
          instr_out   <= '0;
          instr_valid <= 1'b0;
        end else begin
          step_idx  <= next_idx;
          instr_out <= mem[next_idx];
        end
      end
    end
  end

  assign bus.instr_out   = instr_out;
  assign bus.instr_valid = instr_valid;
  assign bus.busy        = (state == S_RUN);
  assign bus.count       = count;
  assign bus.step_idx    = step_idx;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.done_pulse  = done_pulse;

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Sits between the key-conditioning stage and the direction/torque display decoder. It records up to DEPTH drive instructions, one per single-cycle save strobe, and removes the most recent one on delete. On execute it replays the stored list in order, holding each instruction for STEP_CYCLES clocks. Its outputs drive the HEX direction displays and the LEDR torque bars.

Parameters:
DEPTH, 8, maximum stored instructions
INSTR_W, 4, instruction width: [1:0] direction (00 fwd, 01 right, 10 left, 11 reverse), [3:2] torque 0-3
STEP_CYCLES, 50_000_000, clocks each instruction is held during playback (1 s at 50 MHz)

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  synchronous active-low reset
save_pulse  in  1  one-cycle strobe; append instr_in
delete_pulse  in  1  one-cycle strobe; drop last stored entry
execute_pulse  in  1  one-cycle strobe; start playback
instr_in  in  INSTR_W  instruction from switches
instr_out  out  INSTR_W  instruction currently executing; 0 when idle
instr_valid  out  1  high while playing back
busy  out  1  high in RUN
count  out  $clog2(DEPTH+1)  number of stored entries
step_idx  out  $clog2(DEPTH)  index being executed
full  out  1  count==DEPTH
empty  out  1  count==0
done_pulse  out  1  one cycle after the last step completes

Behaviour:
- Reset (reset_n low at a clock edge) forces IDLE and sets count=0, step_idx=0, timer=0, instr_out=0, instr_valid=0, busy=0, done_pulse=0. This holds mid-playback as well: the buffer is cleared.
- Storage is a DEPTH x INSTR_W register array. It is written at index count and is not cleared on reset; only count is reset.
- IDLE strobe priority when strobes coincide: execute > delete > save. Lower-priority strobes in the same cycle are dropped.
  - save: if !full, mem[count]<=instr_in and count++. If full, it is ignored and no wrap occurs.
  - delete: if !empty, count--. If empty, it is ignored and count does not underflow.
  - execute: if !empty, go to RUN with step_idx=0 and timer=0. If empty, stay IDLE and emit no done_pulse.
- RUN:
  - instr_out=mem[step_idx] and instr_valid=1. Both are registered and appear the cycle after the execute strobe is sampled.
  - timer counts 0..STEP_CYCLES-1.
  - At timer==STEP_CYCLES-1: if step_idx==count-1, go to IDLE, assert done_pulse for the next cycle, and set instr_out=0, instr_valid=0. Otherwise step_idx++ and timer=0.
  - save, delete and execute strobes are ignored in RUN. The buffer is preserved after playback, so a repeat execute replays the same list.
- Each step lasts exactly STEP_CYCLES cycles of valid output. Total playback is count*STEP_CYCLES cycles.
- full and empty are combinational from count. busy equals (state==RUN).
- Widths: timer is $clog2(STEP_CYCLES) bits. count saturates at DEPTH.

Decomposition:
- The shared package robot_pkg holds:
  - dir_t enum {DIR_FWD=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_REV=2'b11}
  - instr_t packed struct {logic [1:0] torque; dir_t dir;}
  - state enum {S_IDLE, S_RUN}
  - the constant CLK_HZ=50_000_000
- One sub-module, step_timer: a parameterised down/up counter with a start/clear input and a one-cycle tick at terminal count. The sequencer instantiates it once.

Test Plan:
All scenarios use STEP_CYCLES=4 and DEPTH=8.
1. Save fwd0 (4'b0000), fwd1 (0100), fwd2 (1000), fwd3 (1100) and left3 (1110), then execute -> count=5. instr_out steps 0000, 0100, 1000, 1100, 1110, each for exactly 4 cycles. done_pulse fires 1 cycle after the 20th valid cycle, then instr_out=0.
2. Nine saves -> count=8 and full=1. The 9th value is absent on playback.
3. Save A=0101 and B=1010, delete, then execute -> only 0101 plays, for 4 cycles. A delete on empty keeps count=0.
4. Execute with count=0 -> busy stays 0, no done_pulse, instr_valid=0.
5. Save and execute strobes in the same IDLE cycle with count=2 -> playback starts and count stays 2. save_pulse during RUN leaves count unchanged.
6. Drive reset_n low in the middle of step 2 of a 3-step run -> next cycle busy=0, instr_out=0, count=0. A subsequent execute does nothing.
